clint: RTL and testbench

//   Core-local interruptor: memory-mapped mtime/mtimecmp/msip registers behind a

---
 rtl/clint_pkg.sv | 15 +
 rtl/clint_if.sv | 21 ++
 rtl/clint_timebase.sv | 29 ++
 rtl/clint.sv | 68 ++++++
 tb/tb_clint.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/clint_pkg.sv
// clint_pkg: shared types, register map and byte-merge helper for the CLINT.
package clint_pkg;
  typedef enum logic {ST_IDLE, ST_RESP} state_t;
  typedef enum logic [1:0] {SEL_NONE, SEL_MSIP, SEL_MTIMECMP, SEL_MTIME} sel_t;
  localparam logic [15:0] CLINT_MSIP_OFF     = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] CLINT_MTIME_OFF    = 16'hBFF8;
  localparam logic [63:0] CLINT_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
  function automatic logic [63:0] merge64(input logic [63:0] old, input logic [63:0] wdata,
                                          input logic [7:0] wmask);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i+:8] = wmask[i] ? wdata[8*i+:8] : old[8*i+:8];
    return r;
  endfunction
endpackage

// File: rtl/clint_if.sv
// clint_if: single-outstanding valid/ready request/response port of the CLINT.
interface clint_if #(parameter int ADDR_W = 16);
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_wdata;
  logic [7:0]        req_wmask;
  logic              req_wen;
  logic              req_valid;
  logic              req_ready;
  logic [63:0]       resp_rdata;
  logic              resp_err;
  logic              resp_valid;
  logic              resp_ready;
  modport master (
    output req_addr, req_wdata, req_wmask, req_wen, req_valid, resp_ready,
    input  req_ready, resp_rdata, resp_err, resp_valid
  );
  modport slave (
    input  req_addr, req_wdata, req_wmask, req_wen, req_valid, resp_ready,
    output req_ready, resp_rdata, resp_err, resp_valid
  );
endinterface

// File: rtl/clint_timebase.sv
// clint_timebase: prescaled 64-bit mtime counter; a bus write beats a same-cycle tick.
module clint_timebase import clint_pkg::*; #(
  parameter logic [15:0] TICK_DIV = 16'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wen,
  input  logic [63:0] wdata,
  input  logic [7:0]  wmask,
  output logic [63:0] mtime
);
  logic [15:0] presc;
  logic        tick;
  assign tick = presc == TICK_DIV - 16'd1;
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime <= '0;
      presc <= '0;
    end else if (wen) begin
      mtime <= merge64(mtime, wdata, wmask);
      presc <= '0;
    end else if (tick) begin
      mtime <= mtime + 64'd1;
      presc <= '0;
    end else begin
      presc <= presc + 16'd1;
    end
  end
endmodule

// File: rtl/clint.sv
// clint: memory-mapped msip/mtimecmp/mtime with registered timer and software interrupt levels.
module clint import clint_pkg::*; #(
  parameter logic [15:0] TICK_DIV = 16'd1,
  parameter int          ADDR_W   = 16
) (
  input  logic    clk,
  input  logic    rst,
  clint_if.slave  bus,
  output logic    extint_software,
  output logic    extint_timer
);
  state_t            state, state_nxt;
  sel_t              sel;
  logic [ADDR_W-1:0] word;
  logic [63:0]       mtime, mtimecmp, rd_val;
  logic              msip, accept, wr;
  assign word   = bus.req_addr & ~ADDR_W'(7);
  assign accept = bus.req_valid && bus.req_ready;
  assign wr     = accept && bus.req_wen;
  always_comb begin
    sel = word == ADDR_W'(CLINT_MSIP_OFF)     ? SEL_MSIP :
          word == ADDR_W'(CLINT_MTIMECMP_OFF) ? SEL_MTIMECMP :
          word == ADDR_W'(CLINT_MTIME_OFF)    ? SEL_MTIME : SEL_NONE;
    rd_val = bus.req_wen         ? 64'd0 :
             sel == SEL_MSIP     ? {63'd0, msip} :
             sel == SEL_MTIMECMP ? mtimecmp :
             sel == SEL_MTIME    ? mtime : 64'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end
  always_comb begin
    state_nxt = state == ST_IDLE ? (bus.req_valid  ? ST_RESP : ST_IDLE)
                                 : (bus.resp_ready ? ST_IDLE : ST_RESP);
  end
  always_comb begin
    bus.req_ready  = state == ST_IDLE;
    bus.resp_valid = state == ST_RESP;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.resp_rdata  <= '0;
      bus.resp_err    <= 1'b0;
      msip            <= 1'b0;
      mtimecmp        <= CLINT_MTIMECMP_RST;
      extint_timer    <= 1'b0;
      extint_software <= 1'b0;
    end else begin
      if (accept) begin
        bus.resp_rdata <= rd_val;
        bus.resp_err   <= sel == SEL_NONE;
      end
      if (wr && sel == SEL_MSIP && bus.req_wmask[0]) msip <= bus.req_wdata[0];
      if (wr && sel == SEL_MTIMECMP) mtimecmp <= merge64(mtimecmp, bus.req_wdata, bus.req_wmask);
      extint_timer    <= mtime >= mtimecmp;
      extint_software <= msip;
    end
  end
  clint_timebase #(.TICK_DIV(TICK_DIV)) u_timebase (
    .clk   (clk),
    .rst   (rst),
    .wen   (wr && sel == SEL_MTIME),
    .wdata (bus.req_wdata),
    .wmask (bus.req_wmask),
    .mtime (mtime)
  );
endmodule

// File: tb/tb_clint.sv
// tb_clint: table-driven, hand-written and random bus traffic checked against an edge-indexed model.
module tb_clint;
  localparam int TD = 1;
  typedef struct {
    logic [15:0] addr;
    logic [63:0] wdata;
    logic [7:0]  mask;
    logic        wen;
    logic [63:0] rdata;
    logic        err;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, ext_sw, ext_t;
  int   edges = 0, checks = 0, errors = 0;
  clint_if #(.ADDR_W(16)) bus();
  clint #(.TICK_DIV(16'(TD)), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .extint_software(ext_sw), .extint_timer(ext_t)
  );
  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;
  // Each register is the value it held after a given edge: current since *_e, previous before it.
  logic [63:0] mt_base, mt_prev, cmp, cmp_prev;
  logic        msip, msip_prev;
  int          mt_e, mt_pe, cmp_e, msip_e;
  function automatic logic [63:0] mtime_at(int x);
    return x >= mt_e ? mt_base + 64'((x - mt_e) / TD) : mt_prev + 64'((x - mt_pe) / TD);
  endfunction
  function automatic logic [63:0] cmp_at(int x);
    return x >= cmp_e ? cmp : cmp_prev;
  endfunction
  function automatic logic msip_at(int x);
    return x >= msip_e ? msip : msip_prev;
  endfunction
  function automatic logic [63:0] bytes_merge(logic [63:0] old, logic [63:0] d, logic [7:0] m);
    logic [63:0] bm;
    for (int i = 0; i < 8; i++) bm[8*i+:8] = {8{m[i]}};
    return (old & ~bm) | (d & bm);
  endfunction
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_irq();
    check("extint_timer", 64'(ext_t), 64'(mtime_at(edges - 1) >= cmp_at(edges - 1)));
    check("extint_software", 64'(ext_sw), 64'(msip_at(edges - 1)));
  endtask
  task automatic model_reset();
    mt_base = '0; mt_prev = '0; mt_e = edges; mt_pe = edges;
    cmp = '1; cmp_prev = '1; cmp_e = edges;
    msip = 1'b0; msip_prev = 1'b0; msip_e = edges;
  endtask
  task automatic do_reset(int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask
  task automatic xact(input logic [15:0] addr, input logic [63:0] wd, input logic [7:0] m,
                      input logic wen, output logic [63:0] rd, output logic er,
                      output logic [63:0] exp_rd, output logic exp_er);
    int n = 0, acc;
    logic [15:0] off;
    off = addr & ~16'd7;
    bus.req_addr = addr; bus.req_wdata = wd; bus.req_wmask = m; bus.req_wen = wen;
    bus.req_valid = 1'b1;
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.req_valid = 1'b0;
    acc = edges;
    exp_er = !(off == 16'h0000 || off == 16'h4000 || off == 16'hBFF8);
    exp_rd = wen ? 64'd0 : off == 16'h0000 ? 64'(msip_at(acc - 1)) :
             off == 16'h4000 ? cmp_at(acc - 1) : off == 16'hBFF8 ? mtime_at(acc - 1) : 64'd0;
    if (wen && off == 16'h0000 && m[0]) begin
      msip_prev = msip_at(acc - 1); msip = wd[0]; msip_e = acc;
    end
    if (wen && off == 16'h4000) begin
      cmp_prev = cmp_at(acc - 1); cmp = bytes_merge(cmp_prev, wd, m); cmp_e = acc;
    end
    if (wen && off == 16'hBFF8) begin
      mt_prev = mt_base; mt_pe = mt_e;
      mt_base = bytes_merge(mtime_at(acc - 1), wd, m); mt_e = acc;
    end
    n = 0;
    while (!bus.resp_valid && n < 20) begin @(negedge clk); n++; end
    check("resp_valid_seen", 64'(bus.resp_valid), 64'd1);
    rd = bus.resp_rdata;
    er = bus.resp_err;
    chk_irq();
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    chk_irq();
  endtask
  vec_t vt[14];
  logic [63:0] rd, erd, first;
  logic        er, eer;
  int          rise, acc;
  initial begin
    bus.req_addr = '0; bus.req_wdata = '0; bus.req_wmask = '0; bus.req_wen = 1'b0;
    bus.req_valid = 1'b0; bus.resp_ready = 1'b0;
    vt[0]  = '{16'h0000, 64'h1, 8'h01, 1'b1, 64'h0, 1'b0};
    vt[1]  = '{16'h0000, 64'h0, 8'h00, 1'b0, 64'h1, 1'b0};
    vt[2]  = '{16'h0000, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 1'b1, 64'h0, 1'b0};
    vt[3]  = '{16'h0000, 64'h0, 8'h00, 1'b0, 64'h0, 1'b0};
    vt[4]  = '{16'h0000, 64'h1, 8'h02, 1'b1, 64'h0, 1'b0};
    vt[5]  = '{16'h0000, 64'h0, 8'h00, 1'b0, 64'h0, 1'b0};
    vt[6]  = '{16'h4000, 64'h1122_3344_5566_7788, 8'hFF, 1'b1, 64'h0, 1'b0};
    vt[7]  = '{16'h4000, 64'h0, 8'h00, 1'b0, 64'h1122_3344_5566_7788, 1'b0};
    vt[8]  = '{16'h4000, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, 1'b1, 64'h0, 1'b0};
    vt[9]  = '{16'h4000, 64'h0, 8'h00, 1'b0, 64'h1122_3344_BBBB_BBBB, 1'b0};
    vt[10] = '{16'h1000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1, 64'h0, 1'b1};
    vt[11] = '{16'h1000, 64'h0, 8'h00, 1'b0, 64'h0, 1'b1};
    vt[12] = '{16'h4004, 64'h0, 8'h00, 1'b0, 64'h1122_3344_BBBB_BBBB, 1'b0};
    vt[13] = '{16'h0008, 64'h0, 8'h00, 1'b0, 64'h0, 1'b1};
    do_reset(3);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_resp_rdata", bus.resp_rdata, 64'd0);
    repeat (10) begin @(negedge clk); chk_irq(); end
    xact(16'hBFF8, 64'd0, 8'h00, 1'b0, rd, er, erd, eer);
    check("idle_mtime", rd, erd);
    check("idle_mtime_range", 64'(rd >= 64'd9 && rd <= 64'd11), 64'd1);
    xact(16'hBFF8, 64'd0, 8'hFF, 1'b1, rd, er, erd, eer);
    xact(16'h4000, 64'd20, 8'hFF, 1'b1, rd, er, erd, eer);
    rise = -1;
    for (int i = 0; i < 40 && rise < 0; i++) begin
      @(negedge clk);
      chk_irq();
      if (ext_t) rise = edges;
    end
    if (rise < 0) begin checks++; errors++; $display("FAIL timer_rise: got none expected rise"); end
    else check("timer_rise_mtime", mtime_at(rise - 1), 64'd20);
    xact(16'h4000, '1, 8'hFF, 1'b1, rd, er, erd, eer);
    @(negedge clk);
    check("timer_fall", 64'(ext_t), 64'd0);
    foreach (vt[i]) begin
      xact(vt[i].addr, vt[i].wdata, vt[i].mask, vt[i].wen, rd, er, erd, eer);
      check($sformatf("vec%0d_rdata", i), rd, vt[i].rdata);
      check($sformatf("vec%0d_err", i), 64'(er), 64'(vt[i].err));
    end
    xact(16'h0000, 64'h1, 8'h01, 1'b1, rd, er, erd, eer);
    @(negedge clk);
    check("msip_irq_on", 64'(ext_sw), 64'd1);
    xact(16'h0000, 64'h0, 8'h01, 1'b1, rd, er, erd, eer);
    @(negedge clk);
    check("msip_irq_off", 64'(ext_sw), 64'd0);
    xact(16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 1'b1, rd, er, erd, eer);
    xact(16'hBFF8, 64'd0, 8'h00, 1'b0, rd, er, erd, eer);
    check("wrap_read1", rd, 64'hFFFF_FFFF_FFFF_FFFF);
    check("wrap_read1_model", rd, erd);
    xact(16'hBFF8, 64'd0, 8'h00, 1'b0, rd, er, erd, eer);
    check("wrap_read2", rd, 64'h1);
    // Stalled response: a second request must wait while resp_* hold.
    bus.req_addr = 16'hBFF8; bus.req_wen = 1'b0; bus.req_valid = 1'b1;
    @(negedge clk);
    acc = edges;
    first = mtime_at(acc - 1);
    bus.req_addr = 16'h4000;
    for (int i = 0; i < 5; i++) begin
      check("stall_resp_valid", 64'(bus.resp_valid), 64'd1);
      check("stall_req_ready", 64'(bus.req_ready), 64'd0);
      check("stall_rdata", bus.resp_rdata, first);
      check("stall_err", 64'(bus.resp_err), 64'd0);
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0; bus.req_valid = 1'b0;
    check("release_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("release_req_ready", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    check("no_second_accept", 64'(bus.resp_valid), 64'd0);
    repeat (60) begin
      logic [15:0] a;
      logic [63:0] d;
      case ($urandom_range(0, 4))
        0: a = 16'h0000;
        1: a = 16'h4000;
        2: a = 16'hBFF8;
        3: a = 16'h1000;
        default: a = 16'($urandom);
      endcase
      a = (a & ~16'd7) | 16'($urandom_range(0, 7));
      d = $urandom_range(0, 1) ? 64'($urandom_range(0, 60)) : {$urandom, $urandom};
      xact(a, d, 8'($urandom), 1'($urandom), rd, er, erd, eer);
      check("rand_rdata", rd, erd);
      check("rand_err", 64'(er), 64'(eer));
      repeat ($urandom_range(0, 2)) begin @(negedge clk); chk_irq(); end
    end
    xact(16'h0000, 64'h1, 8'h01, 1'b1, rd, er, erd, eer);
    xact(16'h4000, 64'd5, 8'hFF, 1'b1, rd, er, erd, eer);
    xact(16'hBFF8, 64'd100, 8'hFF, 1'b1, rd, er, erd, eer);
    @(negedge clk);
    check("pre_rst_timer", 64'(ext_t), 64'd1);
    check("pre_rst_sw", 64'(ext_sw), 64'd1);
    bus.req_addr = 16'h0000; bus.req_wen = 1'b0; bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("mid_resp_valid", 64'(bus.resp_valid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("rst_drop_resp", 64'(bus.resp_valid), 64'd0);
    check("rst_timer", 64'(ext_t), 64'd0);
    check("rst_sw", 64'(ext_sw), 64'd0);
    @(negedge clk);
    check("rst_no_late_resp", 64'(bus.resp_valid), 64'd0);
    chk_irq();
    xact(16'h4000, 64'd0, 8'h00, 1'b0, rd, er, erd, eer);
    check("rst_mtimecmp", rd, 64'hFFFF_FFFF_FFFF_FFFF);
    xact(16'h0000, 64'd0, 8'h00, 1'b0, rd, er, erd, eer);
    check("rst_msip", rd, 64'd0);
    xact(16'hBFF8, 64'd0, 8'h00, 1'b0, rd, er, erd, eer);
    check("rst_mtime", rd, erd);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
